// File: rtl/mem_access_unit_if.sv
// Request/response and data_memory signals of mem_access_unit, bundled.
// slave is the unit's view; master is the view of the pipeline plus the memory.
interface mem_access_unit_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_we_in;
  logic [1:0]  req_size_in;
  logic        req_signed_in;
  logic [31:0] req_addr_in;
  logic [31:0] req_wdata_in;
  logic        resp_valid_out;
  logic [31:0] resp_rdata_out;
  logic        resp_misaligned_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_writedata_out;
  logic        mem_re_out;
  logic        mem_we_out;
  logic [1:0]  mem_size_out;
  logic [31:0] mem_readdata_in;

  modport slave (
    input  req_valid_in, req_we_in, req_size_in, req_signed_in, req_addr_in, req_wdata_in,
    input  mem_readdata_in,
    output req_ready_out, resp_valid_out, resp_rdata_out, resp_misaligned_out,
    output mem_addr_out, mem_writedata_out, mem_re_out, mem_we_out, mem_size_out
  );

  modport master (
    output req_valid_in, req_we_in, req_size_in, req_signed_in, req_addr_in, req_wdata_in,
    output mem_readdata_in,
    input  req_ready_out, resp_valid_out, resp_rdata_out, resp_misaligned_out,
    input  mem_addr_out, mem_writedata_out, mem_re_out, mem_we_out, mem_size_out
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-only data memory.
// Sub-word stores become read-modify-write, except in the MMIO region where a read has side effects.
module mem_access_unit #(
  parameter logic [15:0] MMIO_PREFIX = 16'hffff,
  parameter bit          BIG_ENDIAN  = 1'b1
) (
  input logic             clock,
  input logic             reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_ERR, S_ACCESS, S_RMW_RD, S_RMW_WR} state_t;

  state_t      state_q, state_d;
  logic        we_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] merge_q, merge_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_mis_q, resp_mis_d;

  logic        accept;
  logic        req_misaligned;
  logic        req_is_mmio;
  logic [4:0]  req_lsb, lsb_q;
  logic [31:0] req_mask, mask_q;
  logic [31:0] lane_data;
  logic [31:0] load_data;

  // Bit offset of the addressed lane inside the 32-bit word.
  function automatic logic [4:0] lane_lsb(input logic [1:0] size, input logic [1:0] a);
    logic [4:0] r;
    r = 5'd0;
    case (size)
      2'b00:   r = BIG_ENDIAN ? {~a, 3'b000} : {a, 3'b000};
      2'b01:   r = BIG_ENDIAN ? {~a[1], 4'b0000} : {a[1], 4'b0000};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [4:0] lsb);
    logic [31:0] m;
    case (size)
      2'b00:   m = 32'h0000_00ff;
      2'b01:   m = 32'h0000_ffff;
      default: m = 32'hffff_ffff;
    endcase
    return m << lsb;
  endfunction

  assign accept         = bus.req_valid_in && (state_q == S_IDLE);
  assign req_misaligned = (bus.req_size_in == 2'b10)
                       || ((bus.req_size_in == 2'b01) && bus.req_addr_in[0])
                       || ((bus.req_size_in == 2'b11) && (bus.req_addr_in[1:0] != 2'b00));
  assign req_is_mmio    = (bus.req_addr_in[31:16] == MMIO_PREFIX);

  assign req_lsb  = lane_lsb(bus.req_size_in, bus.req_addr_in[1:0]);
  assign req_mask = lane_mask(bus.req_size_in, req_lsb);
  assign lsb_q    = lane_lsb(size_q, addr_q[1:0]);
  assign mask_q   = lane_mask(size_q, lsb_q);

  assign lane_data = bus.mem_readdata_in >> lsb_q;

  always_comb begin
    load_data = lane_data;
    case (size_q)
      2'b00:   load_data = {{24{signed_q & lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_data = {{16{signed_q & lane_data[15]}}, lane_data[15:0]};
      default: load_data = lane_data;
    endcase
  end

  // merge_q first holds the store data already placed in its lane; RMW_RD fills the other lanes.
  always_comb begin
    state_d      = state_q;
    merge_d      = merge_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_mis_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          merge_d = (bus.req_wdata_in << req_lsb) & req_mask;
          if (req_misaligned)
            state_d = S_ERR;
          else if (!bus.req_we_in || (bus.req_size_in == 2'b11) || req_is_mmio)
            state_d = S_ACCESS;
          else
            state_d = S_RMW_RD;
        end
      end
      S_ERR: begin
        resp_valid_d = 1'b1;
        resp_mis_d   = 1'b1;
        state_d      = S_IDLE;
      end
      S_ACCESS: begin
        resp_valid_d = 1'b1;
        resp_rdata_d = we_q ? 32'd0 : load_data;
        state_d      = S_IDLE;
      end
      S_RMW_RD: begin
        merge_d = (bus.mem_readdata_in & ~mask_q) | (merge_q & mask_q);
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= 32'd0;
      merge_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_mis_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      merge_q      <= merge_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_mis_q   <= resp_mis_d;
      if (accept) begin
        we_q     <= bus.req_we_in;
        signed_q <= bus.req_signed_in;
        size_q   <= bus.req_size_in;
        addr_q   <= bus.req_addr_in;
      end
    end
  end

  assign bus.req_ready_out       = (state_q == S_IDLE);
  assign bus.resp_valid_out      = resp_valid_q;
  assign bus.resp_rdata_out      = resp_rdata_q;
  assign bus.resp_misaligned_out = resp_mis_q;
  assign bus.mem_addr_out        = {addr_q[31:2], 2'b00};
  assign bus.mem_writedata_out   = merge_q;
  assign bus.mem_re_out          = (state_q == S_RMW_RD) || ((state_q == S_ACCESS) && !we_q);
  assign bus.mem_we_out          = (state_q == S_RMW_WR) || ((state_q == S_ACCESS) && we_q);
  assign bus.mem_size_out        = 2'b11;

endmodule
